// File: rtl/dmac_pkg.sv
// Shared types for the two-channel DMA scheduler: FSM states, channel index
// and the channel-to-request-bit mapping.
package dmac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    ACK  = 2'd3
  } state_e;

  typedef logic ch_idx_t;

  localparam ch_idx_t CH1 = 1'b0;
  localparam ch_idx_t CH2 = 1'b1;

  // Channel 1 lives on bit 1 of the request/enable/ack vectors, channel 2 on bit 0.
  function automatic logic [1:0] ch_onehot(input ch_idx_t ch);
    return (ch == CH1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmac_rr_picker.sv
// Combinational winner selection. DMAC_SCHED_RR_EN selects round-robin on a
// tie; otherwise channel 1 wins every tie.
module dmac_rr_picker
  import dmac_pkg::*;
(
  input  logic [1:0] req_i,
  input  ch_idx_t    last_i,
  output ch_idx_t    winner_o
);

  always_comb begin
    winner_o = CH1;
    if (req_i == 2'b01) begin
      winner_o = CH2;
    end else if (req_i == 2'b11) begin
`ifdef DMAC_SCHED_RR_EN
      winner_o = (last_i == CH1) ? CH2 : CH1;
`else
      winner_o = CH1;
`endif
    end
  end

`ifndef DMAC_SCHED_RR_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

endmodule

// File: rtl/dmac_channel_sched.sv
// Two-channel DMA scheduler: arbitrates peripheral requests, handshakes with the
// bus arbiter and datapath. Tie policy set by DMAC_SCHED_RR_EN (see picker).
module dmac_channel_sched
  import dmac_pkg::*;
#(
  parameter int GRANT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dmac_req,
  input  logic       bus_grant,
  input  logic       ch_done,
  output logic       bus_req,
  output logic [1:0] ch_en,
  output logic       con_sel,
  output logic [1:0] req_ack,
  output logic       interrupt,
  output logic       timeout_err
);

  localparam logic [7:0] TMO_LAST = 8'(GRANT_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  ch_idx_t    last_q, last_d;
  ch_idx_t    sel_q, sel_d;
  logic       bus_req_q, bus_req_d;
  logic [1:0] ch_en_q, ch_en_d;
  logic [1:0] req_ack_q, req_ack_d;
  logic       irq_q, irq_d;
  logic       tmo_q, tmo_d;
  ch_idx_t    winner;

  dmac_rr_picker u_picker (
    .req_i    (dmac_req),
    .last_i   (last_q),
    .winner_o (winner)
  );

  // Outputs are computed as next-state values so every port comes from a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    bus_req_d = 1'b0;
    ch_en_d   = 2'b00;
    req_ack_d = 2'b00;
    irq_d     = 1'b0;
    tmo_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|dmac_req) begin
          state_d   = REQ;
          sel_d     = winner;
          bus_req_d = 1'b1;
          cnt_d     = 8'd0;
        end
      end
      REQ: begin
        if (bus_grant) begin
          state_d   = XFER;
          bus_req_d = 1'b1;
          ch_en_d   = ch_onehot(sel_q);
          cnt_d     = 8'd0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          bus_req_d = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      XFER: begin
        // Completion outranks a simultaneous grant loss.
        if (ch_done) begin
          state_d   = ACK;
          req_ack_d = ch_onehot(sel_q);
          irq_d     = 1'b1;
          last_d    = sel_q;
        end else if (!bus_grant) begin
          state_d   = REQ;
          bus_req_d = 1'b1;
          cnt_d     = 8'd0;
        end else begin
          bus_req_d = 1'b1;
          ch_en_d   = ch_onehot(sel_q);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      last_q    <= CH2;
      sel_q     <= CH1;
      bus_req_q <= 1'b0;
      ch_en_q   <= 2'b00;
      req_ack_q <= 2'b00;
      irq_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      bus_req_q <= bus_req_d;
      ch_en_q   <= ch_en_d;
      req_ack_q <= req_ack_d;
      irq_q     <= irq_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign ch_en       = ch_en_q;
  assign con_sel     = sel_q;
  assign req_ack     = req_ack_q;
  assign interrupt   = irq_q;
  assign timeout_err = tmo_q;

endmodule
